// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, opcode field
// position, reset address and the all-zero NOP word.
package ifetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  localparam int          OPCODE_MSB       = 31;
  localparam int          OPCODE_LSB       = 26;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage

// File: rtl/ifetch_unit_sat_counter.sv
// Width-parameterised saturating event counter; sticks at all-ones and is cleared
// only by reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, issues ready-handshaked I-cache reads,
// holds the fetched word for the decoder and discards responses made stale by redirects.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              icache_req,
  output logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_ready,
  input  logic [31:0]       icache_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       instr,
  output logic [5:0]        opCode,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [CNT_W-1:0]  fetch_wait_cnt
);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] pend_pc_reg, pend_pc_next;
  logic [31:0]       instr_reg, instr_next;
  logic              valid_reg, valid_next;
  logic              req_reg, req_next;
  logic              ack;
  logic [ADDR_W-1:0] redirect_aligned;

  // A response only counts while our own request is on the bus.
  assign ack              = req_reg & icache_ready;
  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      pc_reg      <= RESET_PC & ~ADDR_W'(3);
      pend_pc_reg <= '0;
      instr_reg   <= NOP_WORD;
      valid_reg   <= 1'b0;
      req_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      pend_pc_reg <= pend_pc_next;
      instr_reg   <= instr_next;
      valid_reg   <= valid_next;
      req_reg     <= req_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    pend_pc_next = pend_pc_reg;
    instr_next   = instr_reg;
    valid_next   = valid_reg;
    req_next     = 1'b0;
    case (state_reg)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        if (ack) begin
          if (redirect_valid) begin
            pc_next = redirect_aligned;
          end else begin
            instr_next = icache_rdata;
            valid_next = 1'b1;
            state_next = S_VALID;
          end
        end else if (redirect_valid) begin
          req_next = 1'b1;
          // Nothing in flight yet: retarget directly instead of draining.
          if (req_reg) begin
            pend_pc_next = redirect_aligned;
            state_next   = S_DRAIN;
          end else begin
            pc_next = redirect_aligned;
          end
        end else begin
          req_next = 1'b1;
        end
      end
      S_DRAIN: begin
        if (ack) begin
          pc_next      = redirect_valid ? redirect_aligned : pend_pc_reg;
          pend_pc_next = '0;
          state_next   = S_FETCH;
        end else begin
          req_next = 1'b1;
          if (redirect_valid) pend_pc_next = redirect_aligned;
        end
      end
      S_VALID: begin
        if (redirect_valid) begin
          pc_next    = redirect_aligned;
          valid_next = 1'b0;
          state_next = S_FETCH;
        end else if (!stall) begin
          pc_next    = pc_reg + ADDR_W'(4);
          valid_next = 1'b0;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (req_reg & ~icache_ready),
    .count (fetch_wait_cnt)
  );

  assign icache_req  = req_reg;
  assign icache_addr = pc_reg;
  assign instr       = instr_reg;
  assign opCode      = instr_reg[OPCODE_MSB:OPCODE_LSB];
  assign instr_valid = valid_reg;
  assign pc          = pc_reg;
  assign pc_plus4    = pc_reg + ADDR_W'(4);

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios then random traffic, checked against a
// transaction-level scoreboard of architectural PC, presented instructions and bus requests.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_ready = 1'b0;
  logic [31:0] icache_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic        icache_req, instr_valid;
  logic [31:0] icache_addr, instr, pc, pc_plus4;
  logic [5:0]  opCode;
  logic [15:0] fetch_wait_cnt;

  logic        q4_req, q4_valid;
  logic [31:0] q4_addr, q4_instr, q4_pc, q4_pc_plus4;
  logic [5:0]  q4_opcode;
  logic [3:0]  q4_cnt;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n), .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_rdata(icache_rdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr(instr),
    .opCode(opCode), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_wait_cnt(fetch_wait_cnt)
  );

  ifetch_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .icache_req(q4_req), .icache_addr(q4_addr),
    .icache_ready(icache_ready), .icache_rdata(icache_rdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr(q4_instr),
    .opCode(q4_opcode), .instr_valid(q4_valid), .pc(q4_pc), .pc_plus4(q4_pc_plus4),
    .fetch_wait_cnt(q4_cnt)
  );

  int          n_pass = 0;
  int          n_total = 0;
  int          presented = 0;
  logic [31:0] exp_pc;
  logic        exp_valid;
  logic        out_active;
  logic [31:0] out_addr;
  logic        doomed;
  int unsigned wait_total;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C08_0004;
    return (a * 32'h9E37_79B1) ^ 32'h3C5A_96E1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    exp_pc = 32'h0; exp_valid = 1'b0; out_active = 1'b0; doomed = 1'b0; wait_total = 0;
  endtask

  task automatic observe();
    logic [31:0] w;
    logic [15:0] e16;
    logic [3:0]  e4;
    w   = mem(exp_pc);
    e16 = (wait_total > 32'd65535) ? 16'hFFFF : 16'(wait_total);
    e4  = (wait_total > 32'd15) ? 4'hF : 4'(wait_total);
    chk("instr_valid", 128'({instr_valid, q4_valid}), 128'({exp_valid, exp_valid}));
    chk("wait_cnt16", 128'(fetch_wait_cnt), 128'(e16));
    chk("wait_cnt4", 128'(q4_cnt), 128'(e4));
    if (exp_valid) begin
      chk("pc", 128'({pc, q4_pc}), 128'({exp_pc, exp_pc}));
      chk("instr", 128'({instr, q4_instr}), 128'({w, w}));
      chk("opcode", 128'({opCode, q4_opcode}), 128'({w[31:26], w[31:26]}));
      chk("pc_plus4", 128'({pc_plus4, q4_pc_plus4}), 128'({exp_pc + 32'd4, exp_pc + 32'd4}));
      chk("req_while_valid", 128'({icache_req, q4_req}), 128'(2'b00));
    end
    if (out_active)
      chk("req_hold", 128'({icache_req, q4_req, icache_addr, q4_addr}), 128'({2'b11, out_addr, out_addr}));
    else if (icache_req)
      chk("req_addr", 128'({icache_addr, q4_addr}), 128'({exp_pc, exp_pc}));
  endtask

  // One clock: check outputs at the falling edge, drive inputs, advance the scoreboard.
  task automatic step(input logic rdy, input logic stl, input logic rv, input logic [31:0] rpc);
    logic req_o, ack;
    @(negedge clk);
    observe();
    req_o = icache_req;
    icache_ready = rdy; icache_rdata = mem(icache_addr);
    stall = stl; redirect_valid = rv; redirect_pc = rpc;
    if (req_o && !out_active) begin out_active = 1'b1; out_addr = icache_addr; end
    ack = req_o && rdy;
    if (req_o && !rdy) wait_total++;
    if (rv) begin
      exp_pc = rpc & ~32'd3;
      if (exp_valid) exp_valid = 1'b0;
      else if (out_active) begin
        if (ack) begin out_active = 1'b0; doomed = 1'b0; end
        else doomed = 1'b1;
      end
    end else if (exp_valid) begin
      if (!stl) begin exp_pc = exp_pc + 32'd4; exp_valid = 1'b0; end
    end else if (ack) begin
      out_active = 1'b0;
      if (doomed) doomed = 1'b0;
      else begin exp_valid = 1'b1; presented++; end
    end
  endtask

  task automatic wait_req(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      seen = icache_req;
    end
    if (!seen) begin
      n_total++;
      $error("FAIL %s: icache_req observed 0 after %0d cycles, expected 1", tag, budget);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_outputs", 128'({icache_req, instr_valid, instr, opCode, pc, pc_plus4, fetch_wait_cnt}),
        128'({1'b0, 1'b0, 32'h0, 6'h0, 32'h0, 32'h4, 16'h0}));
    chk("rst_outputs4", 128'({q4_req, q4_valid, q4_instr, q4_cnt}), 128'({1'b0, 1'b0, 32'h0, 4'h0}));
    rst_n = 1'b1;

    // First fetch: ready two cycles after the request rises.
    wait_req("t1_req", 10);
    chk("t1_addr", 128'(icache_addr), 128'(32'h0));
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t1_opcode", 128'(opCode), 128'(6'b100011));
    chk("t1_cnt", 128'(fetch_wait_cnt), 128'(16'd2));
    chk("t1_pc_plus4", 128'({pc, pc_plus4}), 128'({32'h0, 32'h4}));

    // Five stall cycles, then sequential fetch at 4.
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    wait_req("t2_req", 10);
    chk("t2_addr", 128'(icache_addr), 128'(32'h4));
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect beats stall.
    step(1'b0, 1'b1, 1'b1, 32'h40);
    wait_req("t3_req", 10);
    chk("t3_addr", 128'(icache_addr), 128'(32'h40));
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Two redirects while the fetch of 8 is outstanding: latest wins, data dropped.
    step(1'b0, 1'b0, 1'b1, 32'h8);
    wait_req("t4_req", 10);
    chk("t4_addr8", 128'(icache_addr), 128'(32'h8));
    step(1'b0, 1'b0, 1'b1, 32'h80);
    repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'hC3);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    wait_req("t4_req2", 10);
    chk("t4_addrC0", 128'(icache_addr), 128'(32'hC0));
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // PC wrap with a long wait that saturates the 4-bit counter.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    wait_req("t5_req", 10);
    repeat (19) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t5_wrap", 128'({pc, pc_plus4}), 128'({32'hFFFF_FFFC, 32'h0}));
    chk("t5_sat4", 128'(q4_cnt), 128'(4'hF));
    step(1'b0, 1'b0, 1'b0, 32'h0);
    wait_req("t5_req2", 10);
    chk("t5_addr0", 128'(icache_addr), 128'(32'h0));
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0), $urandom);
    chk("progress", 128'(presented > 60), 128'(1'b1));

    // Reset in the middle of a drain.
    wait_req("t6_req", 20);
    step(1'b0, 1'b0, 1'b1, 32'h200);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async", 128'({icache_req, instr_valid, q4_req, q4_valid, pc, fetch_wait_cnt}),
        128'({4'b0000, 32'h0, 16'h0}));
    icache_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wait_req("t6_req2", 10);
    chk("t6_addr", 128'(icache_addr), 128'(32'h0));
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
